// File: rtl/qar_pkg.sv
`default_nettype none
// ============================================================================
//  qar_pkg
//  Shared constants and types for the qar memory arbiter slice:
//  arbiter state encoding, read-owner encoding, starvation defaults.
//  Revision: 1.0
// ============================================================================
package qar_pkg;

   // Arbiter FSM: data-priority arbitration or forced fetch grant
   typedef enum logic {
      ARB_ST_ARB   = 1'b0,
      ARB_ST_FORCE = 1'b1
   } arb_state_e;

   // Requester that owns the read response returning next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   // Default number of consecutive fetch losses before fetch is forced
   localparam int STARVE_LIMIT_DEF = 4;

   // Counter width large enough for the full 1..15 limit range
   localparam int STARVE_CNT_W = 4;

endpackage : qar_pkg
`default_nettype wire

// File: rtl/qar_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  qar_mem_arbiter_if
//  Bundles the fetch port, the load/store port and the single-port memory
//  bus seen by qar_mem_arbiter. The slave modport is the arbiter's view;
//  the master modport is the view of the core plus memory around it.
//  Revision: 1.0
// ============================================================================
interface qar_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Instruction-fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // Load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // Unified memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_en;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_we, mem_en
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_we, mem_en
   );

endinterface : qar_mem_arbiter_if
`default_nettype wire

// File: rtl/qar_mem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
//  qar_arb_starve_ctr
//  Saturating count of consecutive fetch losses. force_o flags that the
//  count after this cycle's update has reached LIMIT, so the next cycle
//  must grant the fetch port.
//  Revision: 1.0
// ============================================================================
import qar_pkg::*;

module qar_arb_starve_ctr #(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic inc_i,
   input  wire logic clr_i,
   output logic      force_o
);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   // Next count: clear dominates, increment saturates at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_o = (cnt_d == STARVE_CNT_W'(LIMIT));

endmodule : qar_arb_starve_ctr
`default_nettype wire

// File: rtl/qar_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  qar_mem_arbiter
//  Shares one single-port memory between the core fetch port and its
//  load/store port. Data has priority; a pending fetch that loses
//  STARVE_LIMIT times in a row is granted next. Read data (1-cycle
//  latency) is routed back to whichever port issued the read.
//  Optional build macro: QAR_ARB_STATS_EN adds saturating grant / force
//  event counters on extra output ports.
//  Revision: 1.0
// ============================================================================
import qar_pkg::*;

module qar_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  wire logic          clk,
   input  wire logic          rst,
   qar_mem_arbiter_if.slave   bus
`ifdef QAR_ARB_STATS_EN
   ,
   output logic [31:0]        stat_if_grants,
   output logic [31:0]        stat_d_grants,
   output logic [15:0]        stat_force_events
`endif
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              w_sel_if;
   logic              w_sel_d;
   logic              w_inc;
   logic              w_clr;
   logic              w_force;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // Winner selection and starvation-counter control; nothing is granted in reset
   always_comb begin
      w_sel_if = 1'b0;
      w_sel_d  = 1'b0;
      w_inc    = 1'b0;
      w_clr    = 1'b0;
      if (!rst) begin
         if ((state_q == ARB_ST_FORCE) && bus.if_req) begin
            w_sel_if = 1'b1;
         end else if (bus.d_req) begin
            w_sel_d = 1'b1;
         end else if (bus.if_req) begin
            w_sel_if = 1'b1;
         end
         // A lost fetch only counts when it was actually pending
         w_inc = w_sel_d && bus.if_req;
         // Forced cycle always restarts the count, even if fetch went away
         w_clr = w_sel_if || (state_q == ARB_ST_FORCE);
      end
   end

   qar_arb_starve_ctr #(
      .LIMIT   (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_inc),
      .clr_i   (w_clr),
      .force_o (w_force)
   );

   // Next state: FORCE lasts one cycle; entered when the loss count hits the limit
   always_comb begin
      state_d = state_q;
      if (!rst) begin
         if (state_q == ARB_ST_FORCE) begin
            state_d = ARB_ST_ARB;
         end else if (w_force) begin
            state_d = ARB_ST_FORCE;
         end
      end
   end

   // Memory bus from the winner; idle bus drives zeros
   always_comb begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      owner_d     = OWN_NONE;
      if (w_sel_d) begin
         w_mem_addr  = bus.d_addr;
         w_mem_wdata = bus.d_wdata;
         owner_d     = bus.d_we ? OWN_NONE : OWN_D;
      end else if (w_sel_if) begin
         w_mem_addr  = bus.if_addr;
         owner_d     = OWN_IF;
      end
   end

   // FSM state, read owner and per-port held read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_ST_ARB;
         owner_q    <= OWN_NONE;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (owner_q == OWN_IF) begin
            if_rdata_q <= bus.mem_rdata;
         end
         if (owner_q == OWN_D) begin
            d_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.if_gnt    = w_sel_if;
   assign bus.d_gnt     = w_sel_d;
   assign bus.mem_en    = w_sel_if | w_sel_d;
   assign bus.mem_we    = w_sel_d & bus.d_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

   // Owner's port sees memory data directly; the other port keeps its last word
   assign bus.if_rvalid = (owner_q == OWN_IF);
   assign bus.d_rvalid  = (owner_q == OWN_D);
   assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
   assign bus.d_rdata   = (owner_q == OWN_D)  ? bus.mem_rdata : d_rdata_q;

`ifdef QAR_ARB_STATS_EN
   logic [31:0] stat_if_q;
   logic [31:0] stat_d_q;
   logic [15:0] stat_force_q;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_if_q    <= '0;
         stat_d_q     <= '0;
         stat_force_q <= '0;
      end else begin
         if (w_sel_if && (stat_if_q != '1)) begin
            stat_if_q <= stat_if_q + 1'b1;
         end
         if (w_sel_d && (stat_d_q != '1)) begin
            stat_d_q <= stat_d_q + 1'b1;
         end
         if ((state_q == ARB_ST_ARB) && (state_d == ARB_ST_FORCE) &&
             (stat_force_q != '1)) begin
            stat_force_q <= stat_force_q + 1'b1;
         end
      end
   end

   assign stat_if_grants    = stat_if_q;
   assign stat_d_grants     = stat_d_q;
   assign stat_force_events = stat_force_q;
`endif

endmodule : qar_mem_arbiter
`default_nettype wire
